// File: rtl/wvb_readout_arbiter_pkg.sv
// Package shared by the waveform-buffer readout arbiter files.
//   arb_state_t           : readout FSM state encoding
//   L_WVB_ARB_LEN_WIDTH   : width of the word-count-minus-one header field
//   L_WVB_ARB_CNT_WIDTH   : width of the word counters (field + 1 must fit)
//   L_WVB_ARB_SKID_DEPTH  : output skid buffer depth in words
package wvb_readout_arbiter_pkg;

  localparam int L_WVB_ARB_LEN_WIDTH = 12;
  localparam int L_WVB_ARB_CNT_WIDTH = L_WVB_ARB_LEN_WIDTH + 1;
  localparam logic [1:0] L_WVB_ARB_SKID_DEPTH = 2'd2;

  typedef enum logic [2:0] {
    ST_SCAN   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_HDR_OUT = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_SETTLE = 3'd5
  } arb_state_t;

endpackage

// File: rtl/wvb_readout_arbiter_rr_select.sv
// rr_select: combinational round-robin picker.
//   req   : request vector, one bit per channel
//   ptr   : highest-priority channel index (must be < P_N_CHAN)
//   grant : first requesting channel at or above ptr, searching upward with wrap
//   any   : at least one request present (grant is 0 when low)
module rr_select #(
  parameter int P_N_CHAN    = 24,
  parameter int P_SEL_WIDTH = 5
) (
  input  logic [P_N_CHAN-1:0]    req,
  input  logic [P_SEL_WIDTH-1:0] ptr,
  output logic [P_SEL_WIDTH-1:0] grant,
  output logic                   any
);

  logic [P_SEL_WIDTH:0]   sum;
  logic [P_SEL_WIDTH-1:0] idx;

  // Walk offsets from the far end back toward ptr so the nearest requester
  // (smallest offset) is the last one written and therefore wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = P_N_CHAN - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (P_SEL_WIDTH + 1)'(i);
      if (sum >= (P_SEL_WIDTH + 1)'(P_N_CHAN)) begin
        sum = sum - (P_SEL_WIDTH + 1)'(P_N_CHAN);
      end
      idx = sum[P_SEL_WIDTH-1:0];
      if (req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wvb_readout_arbiter.sv
// wvb_readout_arbiter: round-robin scheduler sharing one readout port among
// P_N_CHAN waveform buffers. Per waveform: pick a channel with a pending
// header, present the header, stream its sample words, then retire it with
// a rddone pulse and a header pop.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   chan_en           : per-channel readout enable
//   wvb_hdr_empty     : per-channel header FIFO empty (first-word-fall-through)
//   wvb_hdr_data      : head-of-FIFO headers, channel 0 at the LSBs
//   wvb_data          : waveform read data, valid one cycle after rdreq
//   wvb_hdr_rdreq     : header pop pulse (one-hot)
//   wvb_wvb_rdreq     : waveform word read request (one-hot)
//   wvb_wvb_rddone    : waveform retired pulse (one-hot)
//   out_hdr / out_hdr_valid / out_hdr_ready : header handshake
//   out_data / out_data_valid / out_data_ready / out_data_last : word stream
//   busy              : high in every state except SCAN
//   out_chan          : channel of the current header, only when
//                       WVB_ARB_CHAN_TAG_EN is defined
//
// Handshake rule for both output channels: a transfer happens on a rising
// clock edge where valid and ready are both high; once valid is raised the
// payload stays stable and valid stays high until that transfer.
module wvb_readout_arbiter
  import wvb_readout_arbiter_pkg::*;
#(
  parameter int P_N_CHAN     = 24,
  parameter int P_SEL_WIDTH  = 5,
  parameter int P_DATA_WIDTH = 22,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_LEN_LSB    = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [P_N_CHAN-1:0]              chan_en,
  input  logic [P_N_CHAN-1:0]              wvb_hdr_empty,
  input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]  wvb_hdr_data,
  input  logic [P_N_CHAN*P_DATA_WIDTH-1:0] wvb_data,
  output logic [P_N_CHAN-1:0]              wvb_hdr_rdreq,
  output logic [P_N_CHAN-1:0]              wvb_wvb_rdreq,
  output logic [P_N_CHAN-1:0]              wvb_wvb_rddone,
  output logic [P_HDR_WIDTH-1:0]           out_hdr,
  output logic                             out_hdr_valid,
  input  logic                             out_hdr_ready,
  output logic [P_DATA_WIDTH-1:0]          out_data,
  output logic                             out_data_valid,
  input  logic                             out_data_ready,
  output logic                             out_data_last,
  output logic                             busy
`ifdef WVB_ARB_CHAN_TAG_EN
  ,
  output logic [P_SEL_WIDTH-1:0]           out_chan
`endif
);

  localparam logic [P_N_CHAN-1:0] L_ONE = {{(P_N_CHAN-1){1'b0}}, 1'b1};

  arb_state_t state;

  logic [P_SEL_WIDTH-1:0]         sel;
  logic [P_SEL_WIDTH-1:0]         rr_ptr;
  logic [P_SEL_WIDTH-1:0]         grant;
  logic                           any_req;
  logic [P_N_CHAN-1:0]            req;
  logic [P_N_CHAN-1:0]            sel_onehot;
  logic [L_WVB_ARB_CNT_WIDTH-1:0] words;
  logic [L_WVB_ARB_CNT_WIDTH-1:0] issued;
  logic [L_WVB_ARB_CNT_WIDTH-1:0] sent;
  logic [P_HDR_WIDTH-1:0]         hdr_sel;
  logic [P_DATA_WIDTH-1:0]        rd_word;

  // Skid buffer: fifo_q0 is the head. A word returning while the buffer is
  // empty is presented directly, which gives 1 word/cycle with ready high.
  logic [P_DATA_WIDTH-1:0]        fifo_q0;
  logic [P_DATA_WIDTH-1:0]        fifo_q1;
  logic [1:0]                     fifo_cnt;
  logic [1:0]                     cnt_after_pop;
  logic                           inflight;
  logic                           rdreq_en;
  logic                           pop;
  logic                           pop_fifo;
  logic                           push;
  logic                           last_word;
  logic                           done_pulse;

  assign req = chan_en & ~wvb_hdr_empty;

  rr_select #(
    .P_N_CHAN    (P_N_CHAN),
    .P_SEL_WIDTH (P_SEL_WIDTH)
  ) u_rr_select (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .any   (any_req)
  );

  assign hdr_sel = wvb_hdr_data[sel*P_HDR_WIDTH +: P_HDR_WIDTH];
  assign rd_word = wvb_data[sel*P_DATA_WIDTH +: P_DATA_WIDTH];

  always_comb begin
    sel_onehot = L_ONE << sel;
    // Issue only while the buffer plus the word in flight can still absorb
    // one more return, so a stalled consumer never loses a word.
    rdreq_en = (state == ST_DATA) && (issued < words) &&
               ((fifo_cnt + {1'b0, inflight}) < L_WVB_ARB_SKID_DEPTH);
    out_data_valid = (state == ST_DATA) && ((fifo_cnt != 2'd0) || inflight);
    out_data = '0;
    if (out_data_valid) begin
      out_data = (fifo_cnt != 2'd0) ? fifo_q0 : rd_word;
    end
    last_word     = (sent == (words - L_WVB_ARB_CNT_WIDTH'(1)));
    out_data_last = last_word && out_data_valid;
    pop           = out_data_valid && out_data_ready;
    pop_fifo      = pop && (fifo_cnt != 2'd0);
    push          = inflight && !(pop && (fifo_cnt == 2'd0));
    cnt_after_pop = fifo_cnt - {1'b0, pop_fifo};
    done_pulse    = (state == ST_DONE);
    wvb_wvb_rdreq  = rdreq_en ? sel_onehot : '0;
    wvb_wvb_rddone = done_pulse ? sel_onehot : '0;
    wvb_hdr_rdreq  = done_pulse ? sel_onehot : '0;
    busy           = (state != ST_SCAN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_SCAN;
      sel           <= '0;
      rr_ptr        <= '0;
      out_hdr       <= '0;
      out_hdr_valid <= 1'b0;
      words         <= '0;
      issued        <= '0;
      sent          <= '0;
      fifo_q0       <= '0;
      fifo_q1       <= '0;
      fifo_cnt      <= '0;
      inflight      <= 1'b0;
`ifdef WVB_ARB_CHAN_TAG_EN
      out_chan      <= '0;
`endif
    end else begin
      inflight <= rdreq_en;
      if (rdreq_en) begin
        issued <= issued + L_WVB_ARB_CNT_WIDTH'(1);
      end
      if (pop) begin
        sent <= sent + L_WVB_ARB_CNT_WIDTH'(1);
      end
      if (pop_fifo) begin
        fifo_q0 <= fifo_q1;
      end
      // Write into the first free slot after this cycle's pop (if any).
      if (push) begin
        if (cnt_after_pop == 2'd0) begin
          fifo_q0 <= rd_word;
        end else begin
          fifo_q1 <= rd_word;
        end
      end
      fifo_cnt <= cnt_after_pop + {1'b0, push};

      case (state)
        ST_SCAN: begin
          if (any_req) begin
            sel   <= grant;
            state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          out_hdr       <= hdr_sel;
          words         <= {1'b0, hdr_sel[P_LEN_LSB +: L_WVB_ARB_LEN_WIDTH]} +
                           L_WVB_ARB_CNT_WIDTH'(1);
          issued        <= '0;
          sent          <= '0;
          out_hdr_valid <= 1'b1;
`ifdef WVB_ARB_CHAN_TAG_EN
          out_chan      <= sel;
`endif
          state         <= ST_HDR_OUT;
        end
        ST_HDR_OUT: begin
          if (out_hdr_ready) begin
            out_hdr_valid <= 1'b0;
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          // chan_en is deliberately ignored here: a started waveform finishes.
          if (pop && last_word) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          rr_ptr <= (sel == P_SEL_WIDTH'(P_N_CHAN - 1)) ? '0 : sel + P_SEL_WIDTH'(1);
          state  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // Gives the popped FIFO a cycle to update its empty flag.
          state <= ST_SCAN;
        end
        default: begin
          state <= ST_SCAN;
        end
      endcase
    end
  end

endmodule
